rv_test_monitor: RTL
====================

// Module: rv_test_monitor
// PURPOSE
//  Synthesizable, parametrised riscv-tests completion checker. It replaces the per-test bench logic that polled pc and rs[3].
//  Sits beside Core, snooping retire and data-store traffic. It decides PASS/FAIL/TIMEOUT/HANG, latches the failing test number,
//  and counts cycles and retired instructions. One instance serves every rv32ui-p-* test; only the parameters change.
// PARAMETERS
//  XLEN          32          data/address width
//  MODE          0           0 = PC-trap (retire at PASS_PC, judge by gp); 1 = tohost store
//  PASS_PC       32'h44      retire PC that ends the test in MODE 0
//  TOHOST_ADDR   32'h1000    store address that ends the test in MODE 1
//  TIMEOUT       5000        max cycles in RUN before TIMEOUT (0 = disabled)
//  HANG_LIMIT    64          consecutive retires of the same PC before HANG (0 = disabled)
//  CNT_W         32          width of cycle/retire counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset (0 = reset)
//  start        in   1      IDLE->RUN pulse; ignored outside IDLE
//  clear        in   1      sync return to IDLE from any state, counters zeroed
//  ret_valid    in   1      one instruction retired this cycle
//  ret_pc       in   XLEN   PC of the retired instruction
//  gp_val       in   XLEN   architectural x3, valid when ret_valid
//  st_valid     in   1      data store issued this cycle
//  st_addr      in   XLEN   store address
//  st_data      in   XLEN   store data
//  done         out  1      in PASS/FAIL/TIMEOUT/HANG
//  pass         out  1      test passed
//  fail         out  1      test failed (FAIL, TIMEOUT or HANG)
//  status       out  3      0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
//  fail_num     out  XLEN-1 failing test number (gp>>1 or st_data>>1)
//  cycles       out  CNT_W  cycles spent in RUN
//  retired      out  CNT_W  ret_valid count while in RUN
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE. All outputs 0. Counters, hang counter and last_pc = 0.
//  IDLE: start=1 -> RUN next edge. Counters start from 0.
//  RUN, each edge: cycles += 1 (saturating). retired += ret_valid (saturating). Terminal checks in priority order:
//   1. MODE0: ret_valid && ret_pc==PASS_PC -> PASS if gp_val==1, else FAIL with fail_num=gp_val>>1.
//      MODE1: st_valid && st_addr==TOHOST_ADDR -> PASS if st_data==1, else FAIL with fail_num=st_data>>1.
//      st_data==0 in MODE1 is ignored (no terminal event).
//   2. HANG: ret_valid && ret_pc==last_pc increments hang_cnt; a different PC resets it to 0.
//      hang_cnt reaching HANG_LIMIT-1 with another repeat -> HANG.
//   3. TIMEOUT: cycles==TIMEOUT-1 at the edge and no higher-priority event -> TIMEOUT.
//  Pass/fail event and timeout in the same cycle: the pass/fail event wins.
//  Terminal states are sticky until clear or reset. Counters freeze. Inputs are ignored.
//  Outputs are registered. done/pass/fail/status assert on the edge after the deciding input cycle (latency 1).
//  clear has priority over start and over every terminal event. start and clear together -> IDLE.
//  Reset mid-RUN aborts with no result. Counters saturate at all-ones, no wrap.
// STRUCTURE
//  Package rv_test_pkg: status encoding localparams (ST_IDLE..ST_HANG), MODE_PCTRAP/MODE_TOHOST constants.
//  One sub-module, rv_sat_counter (CNT_W, inc, clr, saturating). Used twice: cycles and retired.
//  FSM, hang detector and result latch stay in the top module.
// TESTING
//  1. MODE0: start, 10 retires, then ret_pc=0x44, gp=1 -> next edge pass=1, status=2, retired=11.
//  2. MODE0: ret_pc=0x44, gp=7 -> fail=1, status=3, fail_num=3. Later retires leave fail_num unchanged.
//  3. MODE1: store to 0x1000 with data 5 -> FAIL, fail_num=2. Store to 0x1004 with data 1 -> no effect.
//  4. TIMEOUT=20, no events -> status=4 on the 20th RUN edge, cycles=20. Pass event on that same cycle -> PASS.
//  5. HANG_LIMIT=4: ret_pc=0x80 retired 5 times in a row -> HANG. 0x80,0x84 alternating forever -> no HANG.
//  6. rst=0 mid-RUN (asynchronous, between edges) -> all outputs 0 immediately. clear in PASS -> IDLE, then start reruns cleanly.

Source files
------------

// File: rtl/rv_test_pkg.sv
// rv_test_pkg: shared constants for the riscv-tests completion monitor.
//   ST_*      status encoding driven on rv_test_monitor.status
//   MODE_*    end-of-test detection schemes selected by the MODE parameter
//   state_t   FSM state type, encoded so that it can be driven straight onto status
package rv_test_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_HANG    = 3'd5;

    localparam int MODE_PCTRAP = 0;
    localparam int MODE_TOHOST = 1;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RUN     = ST_RUN,
        S_PASS    = ST_PASS,
        S_FAIL    = ST_FAIL,
        S_TIMEOUT = ST_TIMEOUT,
        S_HANG    = ST_HANG
    } state_t;

endpackage

// File: rtl/rv_sat_counter.sv
// rv_sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   clr   synchronous clear to zero (wins over inc)
//   inc   count enable
//   q     current count
module rv_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + CNT_W'(1);
    end

endmodule

// File: rtl/rv_test_monitor.sv
// rv_test_monitor: riscv-tests completion checker that snoops retire and store
// traffic and decides PASS / FAIL / TIMEOUT / HANG.
//   clk, rst                       clock and asynchronous active-low reset
//   start                          IDLE->RUN pulse, ignored elsewhere
//   clear                          synchronous return to IDLE, zeroes everything
//   ret_valid, ret_pc, gp_val      retire snoop (gp_val = x3 of the retiring insn)
//   st_valid, st_addr, st_data     data-store snoop
//   done, pass, fail, status       verdict, decoded from the state register
//   fail_num                       failing test number (judged value >> 1)
//   cycles, retired                saturating RUN-time counters, frozen once decided
module rv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               MODE        = 0,
    parameter logic [XLEN-1:0]  PASS_PC     = 32'h44,
    parameter logic [XLEN-1:0]  TOHOST_ADDR = 32'h1000,
    parameter int               TIMEOUT     = 5000,
    parameter int               HANG_LIMIT  = 64,
    parameter int               CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             ret_valid,
    input  logic [XLEN-1:0]  ret_pc,
    input  logic [XLEN-1:0]  gp_val,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       status,
    output logic [XLEN-2:0]  fail_num,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired
);

    state_t            state, state_nx;
    logic [XLEN-1:0]   last_pc;
    logic [31:0]       hang_cnt;
    logic              hit;        // end-of-test event seen this cycle
    logic [XLEN-1:0]   res_val;    // value judged by that event
    logic              hang_hit;
    logic              to_hit;
    logic              running;
    logic              idle_clr;

    assign running  = (state == S_RUN);
    assign idle_clr = clear || (state == S_IDLE);

    always_comb begin
        hit     = 1'b0;
        res_val = gp_val;
        if (MODE == MODE_TOHOST) begin
            // A zero tohost write is not a verdict, just traffic.
            hit     = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
            res_val = st_data;
        end else begin
            hit     = ret_valid && (ret_pc == PASS_PC);
            res_val = gp_val;
        end
    end

    // hang_cnt counts repeats after the first retire of a PC, so HANG fires
    // on the HANG_LIMIT+1-th consecutive retire of the same PC.
    assign hang_hit = (HANG_LIMIT != 0) && ret_valid && (ret_pc == last_pc) &&
                      (hang_cnt == 32'(HANG_LIMIT - 1));
    // cycles still holds the pre-edge value, so TIMEOUT lands on RUN edge number TIMEOUT.
    assign to_hit   = (TIMEOUT != 0) && (cycles == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                if (hit)
                    state_nx = (res_val == XLEN'(1)) ? S_PASS : S_FAIL;
                else if (hang_hit)
                    state_nx = S_HANG;
                else if (to_hit)
                    state_nx = S_TIMEOUT;
            end
            default: state_nx = state;  // verdicts are sticky
        endcase
        if (clear)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc  <= '0;
            hang_cnt <= '0;
            fail_num <= '0;
        end else if (idle_clr) begin
            last_pc  <= '0;
            hang_cnt <= '0;
            fail_num <= '0;
        end else if (running) begin
            if (ret_valid) begin
                if (ret_pc == last_pc) begin
                    if (hang_cnt != '1)
                        hang_cnt <= hang_cnt + 32'd1;
                end else begin
                    hang_cnt <= '0;
                    last_pc  <= ret_pc;
                end
            end
            if (hit && (res_val != XLEN'(1)))
                fail_num <= res_val[XLEN-1:1];
        end
    end

    rv_sat_counter #(.CNT_W(CNT_W)) u_cycles (
        .clk (clk),
        .rst (rst),
        .clr (idle_clr),
        .inc (running),
        .q   (cycles)
    );

    rv_sat_counter #(.CNT_W(CNT_W)) u_retired (
        .clk (clk),
        .rst (rst),
        .clr (idle_clr),
        .inc (running && ret_valid),
        .q   (retired)
    );

    assign status = state;
    assign pass   = (state == S_PASS);
    assign fail   = (state == S_FAIL) || (state == S_TIMEOUT) || (state == S_HANG);
    assign done   = pass || fail;

endmodule
